writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
Register-file writer for the RISC-V pipeline, and the producer of the decode stage's write-port inputs (write value, destination number and write enable).
- Accepts retiring instructions from the memory stage over a valid/ready handshake.
- Waits for load data when it is late and formats loads by width and sign.
- Issues a registered, one-cycle register-file write pulse.

Parameters:
XLEN, 32, data/register width
RD_W, 5, destination register number width

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-low
i_valid  input  1  memory stage presents an instruction
ready  output  1  unit can accept; handshake completes when i_valid&&ready
i_opcode  input  7  instruction opcode
i_func_3  input  3  load width/sign select
i_rd_num  input  RD_W  destination register
i_alu_res  input  XLEN  ALU result / effective address
i_pc  input  XLEN  instruction PC
i_mem_valid  input  1  i_mem_data valid this cycle
i_mem_data  input  XLEN  aligned 32-bit word read from data memory
w_rd  output  XLEN  register write value
w_rd_num  output  RD_W  register write number
reg_op  output  1  register write enable, one-cycle pulse
misalign  output  1  one-cycle pulse: bad load alignment or illegal func_3
retired  output  64  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (i_rst=0, any state, any time): state=IDLE, w_rd=0, w_rd_num=0, reg_op=0, misalign=0, retired=0. Any held load is dropped.
- States: IDLE, WAIT_MEM.
- ready = (state==IDLE); it is combinational from state only.

Accept in IDLE, by opcode:
- OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111: next cycle w_rd=i_alu_res, reg_op=1.
- JAL 1101111, JALR 1100111: next cycle w_rd=i_pc+4 (mod 2^32), reg_op=1.
- LOAD 0000011 with i_mem_valid=1 in the accept cycle: format, then write next cycle.
- LOAD with i_mem_valid=0: latch func_3, rd_num and addr[1:0]=i_alu_res[1:0]; go to WAIT_MEM.
- STORE, BRANCH, SYSTEM and any other opcode: complete with reg_op=0.

WAIT_MEM:
- On i_mem_valid=1: format the load, write next cycle, return to IDLE.
- Otherwise hold indefinitely.
- i_valid is ignored in this state.

Load formatting (byte lane = addr[1:0], halfword lane = addr[1]):
- LB 000: sign-extend the selected byte. LBU 100: zero-extend it.
- LH 001: sign-extend the selected halfword; requires addr[0]=0. LHU 101: zero-extend it; same alignment rule.
- LW 010: whole word; requires addr=00.
- Alignment violation, or func_3 in {011,110,111}: reg_op=0 and misalign=1 for one cycle; the instruction still completes.

Common rules:
- rd_num==0: reg_op forced to 0; w_rd and w_rd_num still update.
- Outputs are registered; latency is 1 cycle from accept (or from i_mem_valid for late loads) to the reg_op pulse.
- reg_op and misalign are 1 only in the completion cycle. w_rd and w_rd_num hold their last value otherwise.
- Back-to-back: an instruction can be accepted every cycle while in IDLE, giving throughput 1/cycle. For a late load, the next accept happens in the cycle after i_mem_valid.

Optional Feature:
Macro WB_RETIRE_CNT_EN.
- Defined: `retired` is a 64-bit counter, incremented by 1 in the completion cycle of every accepted instruction, including no-write and misaligned ones. It wraps at 2^64 and resets to 0.
- Undefined: no counter register; `retired` is tied to 0.

Test Plan:
- Reset: assert i_rst=0 while in WAIT_MEM, release, send i_mem_valid=1 -> no reg_op pulse; ready=1; all outputs 0.
- ALU op: OP, rd=5, alu_res=0x0000_1234 -> one cycle later reg_op=1, w_rd_num=5, w_rd=0x1234; back-to-back LUI rd=6, alu_res=0xABCD_E000 on the next cycle -> consecutive pulses.
- JAL: rd=1, pc=0x0000_0100 -> w_rd=0x104; JAL rd=0 -> reg_op=0.
- Late load: LB rd=7, addr=0x...3, i_mem_valid low for 3 cycles -> ready=0 during the wait; then mem_data=0x80FF_FFFF -> w_rd=0xFFFF_FF80, reg_op=1.
- Load formats, mem_data=0x1234_8765: LHU addr 00 -> 0x0000_8765; LH addr 00 -> 0xFFFF_8765; LH addr 10 -> 0x0000_1234; LW addr 01 -> reg_op=0, misalign=1.
- With WB_RETIRE_CNT_EN: run 10 mixed instructions, including one STORE and one misaligned load -> retired=10; without the macro -> retired=0.

Source files
------------

// File: rtl/writeback_if.sv
// Memory-stage to writeback bundle: the retiring-instruction handshake plus the
// register-file write port that the decode stage consumes.
interface writeback_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            i_valid;
    logic            ready;
    logic [6:0]      i_opcode;
    logic [2:0]      i_func_3;
    logic [RD_W-1:0] i_rd_num;
    logic [XLEN-1:0] i_alu_res;
    logic [XLEN-1:0] i_pc;
    logic            i_mem_valid;
    logic [XLEN-1:0] i_mem_data;
    logic [XLEN-1:0] w_rd;
    logic [RD_W-1:0] w_rd_num;
    logic            reg_op;
    logic            misalign;
    logic [63:0]     retired;

    modport master (
        output i_valid, i_opcode, i_func_3, i_rd_num, i_alu_res, i_pc,
               i_mem_valid, i_mem_data,
        input  ready, w_rd, w_rd_num, reg_op, misalign, retired
    );

    modport slave (
        input  i_valid, i_opcode, i_func_3, i_rd_num, i_alu_res, i_pc,
               i_mem_valid, i_mem_data,
        output ready, w_rd, w_rd_num, reg_op, misalign, retired
    );
endinterface

// File: rtl/writeback_unit.sv
// Register-file writer: accepts retiring instructions, waits for late load data,
// formats loads and issues a registered one-cycle write pulse.
// Optional retired-instruction counter enabled by macro WB_RETIRE_CNT_EN.
module writeback_unit #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic      i_clk,
    input  logic      i_rst,
    writeback_if.slave wb
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t          state, state_next;
    logic [2:0]      held_func_3;
    logic [RD_W-1:0] held_rd_num;
    logic [1:0]      held_addr;

    logic [2:0]      ld_func_3;
    logic [1:0]      ld_addr;
    logic [XLEN-1:0] ld_value;
    logic            ld_bad;
    logic [7:0]      lane_byte;
    logic [15:0]     lane_half;

    logic            done;
    logic            hold_load;
    logic            next_write;
    logic            next_misalign;
    logic [XLEN-1:0] next_value;
    logic [RD_W-1:0] next_rd_num;

    logic [XLEN-1:0] w_rd_q;
    logic [RD_W-1:0] w_rd_num_q;
    logic            reg_op_q;
    logic            misalign_q;

    assign wb.ready    = (state == IDLE);
    assign wb.w_rd     = w_rd_q;
    assign wb.w_rd_num = w_rd_num_q;
    assign wb.reg_op   = reg_op_q;
    assign wb.misalign = misalign_q;

    assign ld_func_3 = (state == IDLE) ? wb.i_func_3 : held_func_3;
    assign ld_addr   = (state == IDLE) ? wb.i_alu_res[1:0] : held_addr;

    always_comb begin
        ld_value  = '0;
        ld_bad    = 1'b0;
        lane_byte = wb.i_mem_data[7:0];
        lane_half = ld_addr[1] ? wb.i_mem_data[31:16] : wb.i_mem_data[15:0];
        case (ld_addr)
            2'd1:    lane_byte = wb.i_mem_data[15:8];
            2'd2:    lane_byte = wb.i_mem_data[23:16];
            2'd3:    lane_byte = wb.i_mem_data[31:24];
            default: lane_byte = wb.i_mem_data[7:0];
        endcase
        case (ld_func_3)
            3'b000: ld_value = {{(XLEN-8){lane_byte[7]}}, lane_byte};
            3'b100: ld_value = {{(XLEN-8){1'b0}}, lane_byte};
            3'b001: begin
                ld_value = {{(XLEN-16){lane_half[15]}}, lane_half};
                ld_bad   = ld_addr[0];
            end
            3'b101: begin
                ld_value = {{(XLEN-16){1'b0}}, lane_half};
                ld_bad   = ld_addr[0];
            end
            3'b010: begin
                ld_value = wb.i_mem_data;
                ld_bad   = (ld_addr != 2'b00);
            end
            default: ld_bad = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Decide completion and the write to present next cycle; stores, branches
    // and unknown opcodes complete without touching the register file.
    always_comb begin
        state_next    = state;
        done          = 1'b0;
        hold_load     = 1'b0;
        next_write    = 1'b0;
        next_misalign = 1'b0;
        next_value    = '0;
        next_rd_num   = wb.i_rd_num;
        case (state)
            IDLE: begin
                if (wb.i_valid) begin
                    case (wb.i_opcode)
                        OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                            done       = 1'b1;
                            next_write = 1'b1;
                            next_value = wb.i_alu_res;
                        end
                        OPC_JAL, OPC_JALR: begin
                            done       = 1'b1;
                            next_write = 1'b1;
                            next_value = wb.i_pc + XLEN'(4);
                        end
                        OPC_LOAD: begin
                            if (wb.i_mem_valid) begin
                                done          = 1'b1;
                                next_write    = !ld_bad;
                                next_misalign = ld_bad;
                                next_value    = ld_value;
                            end else begin
                                hold_load  = 1'b1;
                                state_next = WAIT_MEM;
                            end
                        end
                        default: done = 1'b1;
                    endcase
                end
            end
            WAIT_MEM: begin
                next_rd_num = held_rd_num;
                if (wb.i_mem_valid) begin
                    done          = 1'b1;
                    next_write    = !ld_bad;
                    next_misalign = ld_bad;
                    next_value    = ld_value;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            held_func_3 <= '0;
            held_rd_num <= '0;
            held_addr   <= '0;
        end else if (hold_load) begin
            held_func_3 <= wb.i_func_3;
            held_rd_num <= wb.i_rd_num;
            held_addr   <= wb.i_alu_res[1:0];
        end
    end

    // Writes to x0 still update the visible value and number, only the enable is masked.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            w_rd_q     <= '0;
            w_rd_num_q <= '0;
            reg_op_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            reg_op_q   <= 1'b0;
            misalign_q <= 1'b0;
            if (done) begin
                misalign_q <= next_misalign;
                if (next_write) begin
                    w_rd_q     <= next_value;
                    w_rd_num_q <= next_rd_num;
                    reg_op_q   <= (next_rd_num != '0);
                end
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retired_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            retired_q <= '0;
        end else if (done) begin
            retired_q <= retired_q + 64'd1;
        end
    end

    assign wb.retired = retired_q;
`else
    assign wb.retired = '0;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed instructions, a per-instruction
// expectation model and a per-cycle compare process.
module tb_writeback_unit;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct {
        int          cyc;
        logic        reg_op;
        logic        misalign;
        logic        chk_data;
        logic [31:0] w_rd;
        logic [4:0]  rd;
        logic        lit_chk;
        logic [31:0] lit;
    } exp_t;

    logic i_clk;
    logic i_rst;
    int   cyc;
    int   checks;
    int   errors;
    logic exp_ready;
    logic ready_next;
    logic [63:0] exp_retired;
    exp_t exp_q[$];

    logic [2:0]  pend_f3;
    logic [4:0]  pend_rd;
    logic [31:0] pend_alu;

    writeback_if #(.XLEN(32), .RD_W(5)) wb ();

    writeback_unit #(.XLEN(32), .RD_W(5)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .wb    (wb)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required end before 200000");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    // What a completed instruction must produce, straight from the opcode/load rules.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                   input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] mem);
        exp_t e;
        int a;
        logic [31:0] b, h, w;
        logic bad;
        e = '{cyc: 0, reg_op: 1'b0, misalign: 1'b0, chk_data: 1'b0, w_rd: 32'd0, rd: rd,
              lit_chk: 1'b0, lit: 32'd0};
        a = int'(alu & 32'd3);
        b = (mem >> (8 * a)) & 32'hFF;
        h = (mem >> (16 * (a / 2))) & 32'hFFFF;
        w = 32'd0;
        bad = 1'b0;
        if (op == OPC_OP || op == OPC_OP_IMM || op == OPC_LUI || op == OPC_AUIPC) begin
            e.w_rd = alu;
            e.chk_data = 1'b1;
            e.reg_op = (rd != 0);
        end else if (op == OPC_JAL || op == OPC_JALR) begin
            e.w_rd = pc + 32'd4;
            e.chk_data = 1'b1;
            e.reg_op = (rd != 0);
        end else if (op == OPC_LOAD) begin
            case (f3)
                3'd0: w = (b >= 128) ? b + 32'hFFFFFF00 : b;
                3'd4: w = b;
                3'd1: begin bad = (a % 2 != 0); w = (h >= 32768) ? h + 32'hFFFF0000 : h; end
                3'd5: begin bad = (a % 2 != 0); w = h; end
                3'd2: begin bad = (a != 0); w = mem; end
                default: bad = 1'b1;
            endcase
            e.misalign = bad;
            if (!bad) begin
                e.w_rd = w;
                e.chk_data = 1'b1;
                e.reg_op = (rd != 0);
            end
        end
        return e;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
        exp_ready = ready_next;
    endtask

    task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                  input logic [31:0] alu, input logic [31:0] pc, input logic mv,
                                  input logic [31:0] mem, input logic lit_chk, input logic [31:0] lit);
        exp_t e;
        step();
        wb.i_valid     = 1'b1;
        wb.i_opcode    = op;
        wb.i_func_3    = f3;
        wb.i_rd_num    = rd;
        wb.i_alu_res   = alu;
        wb.i_pc        = pc;
        wb.i_mem_valid = mv;
        wb.i_mem_data  = mem;
        if (op == OPC_LOAD && !mv) begin
            pend_f3 = f3;
            pend_rd = rd;
            pend_alu = alu;
            ready_next = 1'b0;
        end else begin
            e = model(op, f3, rd, alu, pc, mem);
            e.cyc = cyc + 1;
            e.lit_chk = lit_chk;
            e.lit = lit;
            exp_q.push_back(e);
            ready_next = 1'b1;
        end
    endtask

    // Junk instructions are presented while waiting; they must be ignored.
    task automatic wait_mem(input int n);
        repeat (n) begin
            step();
            wb.i_valid     = 1'b1;
            wb.i_opcode    = OPC_OP;
            wb.i_rd_num    = 5'd9;
            wb.i_alu_res   = 32'hDEAD_BEEF;
            wb.i_mem_valid = 1'b0;
        end
    endtask

    task automatic deliver(input logic [31:0] mem, input logic lit_chk, input logic [31:0] lit);
        exp_t e;
        step();
        wb.i_valid     = 1'b1;
        wb.i_opcode    = OPC_OP;
        wb.i_rd_num    = 5'd9;
        wb.i_alu_res   = 32'hDEAD_BEEF;
        wb.i_mem_valid = 1'b1;
        wb.i_mem_data  = mem;
        e = model(OPC_LOAD, pend_f3, pend_rd, pend_alu, 32'd0, mem);
        e.cyc = cyc + 1;
        e.lit_chk = lit_chk;
        e.lit = lit;
        exp_q.push_back(e);
        ready_next = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            wb.i_valid     = 1'b0;
            wb.i_mem_valid = 1'b0;
        end
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        logic e_reg, e_mis;
        logic [63:0] e_ret;
        if (!i_rst) begin
            exp_retired = 64'd0;
            check_output("rst_reg_op", {63'd0, wb.reg_op}, 64'd0);
            check_output("rst_misalign", {63'd0, wb.misalign}, 64'd0);
            check_output("rst_w_rd", {32'd0, wb.w_rd}, 64'd0);
            check_output("rst_w_rd_num", {59'd0, wb.w_rd_num}, 64'd0);
            check_output("rst_ready", {63'd0, wb.ready}, 64'd1);
            check_output("rst_retired", wb.retired, 64'd0);
        end else begin
            e_reg = 1'b0;
            e_mis = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                check_output("stale_expectation", 64'(cyc), 64'(e.cyc));
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                exp_retired = exp_retired + 64'd1;
                e_reg = e.reg_op;
                e_mis = e.misalign;
                if (e.chk_data) begin
                    check_output("w_rd", {32'd0, wb.w_rd}, {32'd0, e.w_rd});
                    check_output("w_rd_num", {59'd0, wb.w_rd_num}, {59'd0, e.rd});
                end
                if (e.lit_chk) check_output("w_rd_literal", {32'd0, wb.w_rd}, {32'd0, e.lit});
            end
`ifdef WB_RETIRE_CNT_EN
            e_ret = exp_retired;
`else
            e_ret = 64'd0;
`endif
            check_output("reg_op", {63'd0, wb.reg_op}, {63'd0, e_reg});
            check_output("misalign", {63'd0, wb.misalign}, {63'd0, e_mis});
            check_output("ready", {63'd0, wb.ready}, {63'd0, exp_ready});
            check_output("retired", wb.retired, e_ret);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        exp_ready = 1'b1;
        ready_next = 1'b1;
        exp_retired = 64'd0;
        pend_f3 = '0;
        pend_rd = '0;
        pend_alu = '0;
        wb.i_valid = 1'b0;
        wb.i_opcode = '0;
        wb.i_func_3 = '0;
        wb.i_rd_num = '0;
        wb.i_alu_res = '0;
        wb.i_pc = '0;
        wb.i_mem_valid = 1'b0;
        wb.i_mem_data = '0;
        i_rst = 1'b1;
        #1 i_rst = 1'b0;
        idle(3);
        i_rst = 1'b1;
        idle(1);

        // ALU results back to back, then links including x0 and PC wrap
        apply_stimulus(OPC_OP,  3'd0, 5'd5, 32'h0000_1234, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0000_1234);
        apply_stimulus(OPC_LUI, 3'd0, 5'd6, 32'hABCD_E000, 32'd0, 1'b0, 32'd0, 1'b1, 32'hABCD_E000);
        apply_stimulus(OPC_JAL, 3'd0, 5'd1, 32'd0, 32'h0000_0100, 1'b0, 32'd0, 1'b1, 32'h0000_0104);
        apply_stimulus(OPC_JAL, 3'd0, 5'd0, 32'd0, 32'h0000_0200, 1'b0, 32'd0, 1'b1, 32'h0000_0204);
        apply_stimulus(OPC_JALR, 3'd0, 5'd3, 32'd0, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b1, 32'h0000_0000);
        idle(1);

        // Late signed byte load, then an accept right after the data arrives
        apply_stimulus(OPC_LOAD, 3'b000, 5'd7, 32'h0000_1003, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        wait_mem(3);
        deliver(32'h80FF_FFFF, 1'b1, 32'hFFFF_FF80);
        apply_stimulus(OPC_OP_IMM, 3'd0, 5'd8, 32'h0000_0042, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0042);

        // Load formats with data available at accept
        apply_stimulus(OPC_LOAD, 3'b101, 5'd10, 32'h0000_2000, 32'd0, 1'b1, 32'h1234_8765, 1'b1, 32'h0000_8765);
        apply_stimulus(OPC_LOAD, 3'b001, 5'd11, 32'h0000_2000, 32'd0, 1'b1, 32'h1234_8765, 1'b1, 32'hFFFF_8765);
        apply_stimulus(OPC_LOAD, 3'b001, 5'd12, 32'h0000_2002, 32'd0, 1'b1, 32'h1234_8765, 1'b1, 32'h0000_1234);
        apply_stimulus(OPC_LOAD, 3'b010, 5'd13, 32'h0000_2001, 32'd0, 1'b1, 32'h1234_8765, 1'b0, 32'd0);
        apply_stimulus(OPC_LOAD, 3'b100, 5'd14, 32'h0000_2001, 32'd0, 1'b1, 32'h1234_8765, 1'b1, 32'h0000_0087);
        apply_stimulus(OPC_LOAD, 3'b000, 5'd15, 32'h0000_2001, 32'd0, 1'b1, 32'h1234_8765, 1'b1, 32'hFFFF_FF87);
        apply_stimulus(OPC_LOAD, 3'b001, 5'd16, 32'h0000_2001, 32'd0, 1'b1, 32'h1234_8765, 1'b0, 32'd0);
        apply_stimulus(OPC_LOAD, 3'b011, 5'd17, 32'h0000_2000, 32'd0, 1'b1, 32'h1234_8765, 1'b0, 32'd0);
        apply_stimulus(OPC_LOAD, 3'b010, 5'd0,  32'h0000_2000, 32'd0, 1'b1, 32'h1234_8765, 1'b1, 32'h1234_8765);
        idle(2);

        // Reset while a load is held; data arriving afterwards must not write
        apply_stimulus(OPC_LOAD, 3'b010, 5'd20, 32'h0000_3000, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        wait_mem(2);
        step();
        i_rst = 1'b0;
        wb.i_valid = 1'b0;
        wb.i_mem_valid = 1'b0;
        exp_ready = 1'b1;
        ready_next = 1'b1;
        idle(1);
        i_rst = 1'b1;
        step();
        wb.i_valid = 1'b0;
        wb.i_mem_valid = 1'b1;
        wb.i_mem_data = 32'h5555_AAAA;
        idle(2);

        // Ten mixed instructions, including a store and a misaligned load
        apply_stimulus(OPC_OP,     3'd0,   5'd1, 32'h0000_0011, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        apply_stimulus(OPC_STORE,  3'b010, 5'd2, 32'h0000_4000, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        apply_stimulus(OPC_LOAD,   3'b010, 5'd3, 32'h0000_4002, 32'd0, 1'b1, 32'hCAFE_F00D, 1'b0, 32'd0);
        apply_stimulus(OPC_LUI,    3'd0,   5'd4, 32'h1234_5000, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        apply_stimulus(OPC_JAL,    3'd0,   5'd5, 32'd0, 32'h0000_0800, 1'b0, 32'd0, 1'b1, 32'h0000_0804);
        apply_stimulus(OPC_LOAD,   3'b010, 5'd6, 32'h0000_4004, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        wait_mem(1);
        deliver(32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);
        apply_stimulus(OPC_AUIPC,  3'd0,   5'd7, 32'h0000_9000, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        apply_stimulus(OPC_BRANCH, 3'd0,   5'd8, 32'h0000_0000, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        apply_stimulus(OPC_OP_IMM, 3'd0,   5'd9, 32'h0000_0077, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        apply_stimulus(OPC_SYSTEM, 3'd0,   5'd0, 32'h0000_0000, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        idle(3);
`ifdef WB_RETIRE_CNT_EN
        check_output("retired_total", wb.retired, 64'd10);
`else
        check_output("retired_total", wb.retired, 64'd0);
`endif
        check_output("pending_expectations", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
